// File: rtl/nes_poll_sequencer.sv
// NES controller poll sequencer: periodically latches the pad, shifts out its
// serial button bits and presents them as an active-high parallel word.
module nes_poll_sequencer #(
  parameter int TICK_DIV     = 300,
  parameter int BUTTONS      = 8,
  parameter int PERIOD_TICKS = 2778
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               nes_data,
  output logic               nes_latch,
  output logic               nes_clk,
  output logic [BUTTONS-1:0] buttons,
  output logic               valid,
  output logic               busy
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int PER_W   = $clog2(PERIOD_TICKS);
  localparam int IDX_W   = $clog2(BUTTONS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    PLOW  = 2'd2,
    PHIGH = 2'd3
  } state_e;

  state_e             state_q;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic               data_meta_q, data_sync_q;
  logic               latch_sub_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [BUTTONS-1:0] shift_q;
  logic [BUTTONS-1:0] shift_in;
  logic [BUTTONS-1:0] buttons_q;
  logic               nes_latch_q, nes_clk_q, valid_q, busy_q;
  logic               tick;
  logic               period_sat;
  logic               poll_start;

  // The protocol tick fires on the last cycle of each prescaler period.
  assign tick       = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign presc_d    = tick ? '0 : presc_q + 1'b1;
  assign period_sat = (period_q == PER_W'(PERIOD_TICKS - 1));
  assign poll_start = tick && (state_q == IDLE) && enable && period_sat;
  assign shift_in   = {data_sync_q, shift_q[BUTTONS-1:1]};

  always_comb begin
    period_d = period_q;
    if (poll_start) begin
      period_d = '0;
    end else if (tick && !period_sat) begin
      period_d = period_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      period_q    <= PER_W'(PERIOD_TICKS - 1);
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      period_q    <= period_d;
      data_meta_q <= nes_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Bits enter at the top and move down, so the first bit shifted ends in bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      latch_sub_q <= 1'b0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      buttons_q   <= '0;
      nes_latch_q <= 1'b0;
      nes_clk_q   <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (poll_start) begin
              state_q     <= LATCH;
              latch_sub_q <= 1'b0;
              nes_latch_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
          LATCH: begin
            if (!latch_sub_q) begin
              latch_sub_q <= 1'b1;
            end else begin
              shift_q     <= shift_in;
              nes_latch_q <= 1'b0;
              bit_idx_q   <= IDX_W'(1);
              state_q     <= PLOW;
            end
          end
          PLOW: begin
            nes_clk_q <= 1'b1;
            state_q   <= PHIGH;
          end
          PHIGH: begin
            nes_clk_q <= 1'b0;
            shift_q   <= shift_in;
            if (bit_idx_q == IDX_W'(BUTTONS - 1)) begin
              buttons_q <= ~shift_in;
              valid_q   <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              state_q   <= PLOW;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign nes_latch = nes_latch_q;
  assign nes_clk   = nes_clk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Bench for nes_poll_sequencer: a pad model drives nes_data while a tick-level
// protocol model predicts every output cycle by cycle.
module tb_nes_poll_sequencer;

  localparam int TD         = 4;
  localparam int NB         = 8;
  localparam int PT         = 20;
  localparam int POLL_TICKS = 2 + 2 * (NB - 1);

  logic          clk;
  logic          reset;
  logic          enable;
  logic          nes_data;
  logic          nes_latch;
  logic          nes_clk;
  logic [NB-1:0] buttons;
  logic          valid;
  logic          busy;

  int checks = 0;
  int errors = 0;

  nes_poll_sequencer #(
    .TICK_DIV    (TD),
    .BUTTONS     (NB),
    .PERIOD_TICKS(PT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_clk  (nes_clk),
    .buttons  (buttons),
    .valid    (valid),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: ticks counted with arithmetic on cycles since reset,
  // a poll is a 16-tick window, odd tick indices end with a bit sample.
  int            mCyc     = 0;
  int            mSince   = PT;
  bit            mActive  = 1'b0;
  int            mPollT   = 0;
  logic [NB-1:0] mBits    = '0;
  logic          hist0    = 1'b0;
  logic          hist1    = 1'b0;
  logic          syncVal;
  bit            tickNow;
  logic [NB-1:0] expButtons = '0;
  logic          expValid   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mCyc       = 0;
      mSince     = PT;
      mActive    = 1'b0;
      mPollT     = 0;
      mBits      = '0;
      hist0      = 1'b0;
      hist1      = 1'b0;
      expButtons = '0;
      expValid   = 1'b0;
    end else begin
      tickNow  = ((mCyc % TD) == TD - 1);
      syncVal  = hist1;
      expValid = 1'b0;
      if (tickNow) begin
        if (mSince < PT) mSince++;
        if (mActive) begin
          if (mPollT % 2 == 1) mBits[(mPollT - 1) / 2] = syncVal;
          mPollT++;
          if (mPollT == POLL_TICKS) begin
            mActive    = 1'b0;
            expButtons = ~mBits;
            expValid   = 1'b1;
          end
        end else if (enable && mSince >= PT) begin
          mActive = 1'b1;
          mPollT  = 0;
          mSince  = 0;
        end
      end
      hist1 = hist0;
      hist0 = nes_data;
      mCyc++;
    end
  end

  // Pad model: reloads on latch, advances on each nes_clk rise, drives active-low.
  logic [NB-1:0] pattern    = '0;
  bit            randomMode = 1'b0;
  int            ctrlIdx    = 0;
  logic          prevPadClk = 1'b0;

  initial begin
    nes_data = 1'b1;
    forever begin
      @(negedge clk);
      #($urandom_range(0, 3));
      if (randomMode) begin
        nes_data = 1'($urandom_range(0, 1));
      end else begin
        if (nes_latch) ctrlIdx = 0;
        else if (nes_clk && !prevPadClk) ctrlIdx++;
        prevPadClk = nes_clk;
        nes_data   = (ctrlIdx < NB) ? ~pattern[ctrlIdx] : 1'b1;
      end
    end
  end

  int   tbCyc      = 0;
  logic prevLatch  = 1'b0;
  int   riseCyc[$];
  int   busyCount  = 0;
  int   validCount = 0;
  int   lastValid  = -1;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, exp, tbCyc);
    end
  endtask

  task automatic checkWord(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, tbCyc);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, tbCyc);
    end
  endtask

  task automatic stepCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tbCyc++;
      checkBit("latch", nes_latch, mActive && (mPollT < 2));
      checkBit("nesclk", nes_clk, mActive && (mPollT >= 3) && (mPollT % 2 == 1));
      checkBit("busy", busy, mActive);
      checkBit("valid", valid, expValid);
      checkWord("buttons", buttons, expButtons);
      if (nes_latch && !prevLatch) riseCyc.push_back(tbCyc);
      prevLatch = nes_latch;
      if (busy) busyCount++;
      if (valid) begin
        validCount++;
        lastValid = tbCyc;
      end
    end
  endtask

  task automatic restartCounters();
    tbCyc      = 0;
    prevLatch  = 1'b0;
    riseCyc.delete();
    busyCount  = 0;
    validCount = 0;
    lastValid  = -1;
  endtask

  int dropCyc;
  int risesAtDrop;
  int relatch;

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    pattern = 8'b0000_1001;
    #12;
    checkBit("rst_latch", nes_latch, 1'b0);
    checkBit("rst_nesclk", nes_clk, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_valid", valid, 1'b0);
    checkWord("rst_buttons", buttons, '0);

    // First poll: latch at cycle 4, valid at 68, busy for 64 cycles.
    @(negedge clk);
    reset = 1'b0;
    restartCounters();
    stepCheck(72);
    checkInt("first_latch_cyc", (riseCyc.size() > 0) ? riseCyc[0] : -1, 4);
    checkInt("busy_cycles", busyCount, 64);
    checkInt("valid_count", validCount, 1);
    checkInt("valid_cyc", lastValid, 68);
    checkWord("a_start", buttons, 8'h09);

    // Second frame, nothing pressed, one period after the first.
    pattern = 8'h00;
    stepCheck(80);
    checkInt("period_cycles", (riseCyc.size() > 1) ? riseCyc[1] - riseCyc[0] : -1, PT * TD);
    checkWord("no_press", buttons, 8'h00);

    // Drop enable during pulse 3; the frame must still complete.
    pattern = 8'($urandom);
    stepCheck(41);
    enable      = 1'b0;
    dropCyc     = tbCyc;
    risesAtDrop = riseCyc.size();
    stepCheck(60);
    checkInt("valid_after_drop", validCount, 3);
    checkWord("drop_frame", buttons, pattern);
    checkInt("no_latch_disabled", riseCyc.size(), risesAtDrop);

    enable  = 1'b1;
    dropCyc = tbCyc;
    stepCheck(8);
    checkInt("relatch_count", riseCyc.size(), risesAtDrop + 1);
    relatch = riseCyc[riseCyc.size() - 1] - dropCyc;
    checkBit("relatch_next_tick", (relatch >= 1) && (relatch <= TD), 1'b1);

    // Reset during pulse 5: everything clears at once, no valid.
    stepCheck(40);
    #2;
    reset = 1'b1;
    #1;
    checkBit("mid_rst_latch", nes_latch, 1'b0);
    checkBit("mid_rst_nesclk", nes_clk, 1'b0);
    checkBit("mid_rst_busy", busy, 1'b0);
    checkBit("mid_rst_valid", valid, 1'b0);
    checkWord("mid_rst_buttons", buttons, '0);
    pattern = 8'hFF;
    @(negedge clk);
    reset = 1'b0;
    restartCounters();
    stepCheck(72);
    checkInt("restart_latch_cyc", (riseCyc.size() > 0) ? riseCyc[0] : -1, 4);
    checkInt("restart_valid_cyc", lastValid, 68);
    checkWord("all_pressed", buttons, 8'hFF);

    // Random patterns through the pad model.
    for (int f = 0; f < 3; f++) begin
      pattern = 8'($urandom);
      stepCheck(80);
      checkWord("rand_frame", buttons, pattern);
    end

    // nes_data toggling at random points within the cycle.
    randomMode = 1'b1;
    stepCheck(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
